// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl: multi-byte sequencer driving an 8-bit 74181-style ALU one byte per cycle, LSB first
// Ports: clk/rst_n (sync, active-low); req_* request channel (valid/ready, op, A, B);
//        rsp_* response channel (valid/ready, result, carry, ovf, eq, err); busy;
//        alu_* drive (a, b, s, m, cin active-low) and return (f, cout active-low, eq, ovf).
module ula_seq_ctrl #(
    parameter int NUM_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [8*NUM_BYTES-1:0] req_a,
    input  logic [8*NUM_BYTES-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [8*NUM_BYTES-1:0] rsp_result,
    output logic                   rsp_carry,
    output logic                   rsp_ovf,
    output logic                   rsp_eq,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cin,
    input  logic [7:0]             alu_f,
    input  logic                   alu_cout,
    input  logic                   alu_eq,
    input  logic                   alu_ovf
);
    localparam int W = 8*NUM_BYTES;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_CMP = 3'd5;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t         state_q;
    logic [2:0]     op_q, idx_q;
    logic [W-1:0]   a_q, b_q, res_q;
    logic           eq_acc_q, cout_q, valid_q, carry_q, ovf_q, eq_q, err_q;
    logic           arith, last;
    assign arith      = op_q == OP_ADD || op_q == OP_SUB || op_q == OP_CMP;
    assign last       = idx_q == 3'(NUM_BYTES-1);
    assign req_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign rsp_valid  = valid_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_eq     = eq_q;
    assign rsp_err    = err_q;
    always_comb begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_s   = 4'b0000;
        alu_m   = 1'b1;
        alu_cin = 1'b1;
        if (state_q == EXEC) begin
            alu_a   = a_q[8*idx_q +: 8];
            alu_b   = b_q[8*idx_q +: 8];
            alu_s   = op_q == OP_ADD ? 4'b1001 : op_q == OP_AND ? 4'b1011 : op_q == OP_OR ? 4'b1110 : 4'b0110;
            alu_m   = ~arith;
            // SUB injects the +1 of two's complement on pass 0; CMP leaves it out so F = A-B-1
            alu_cin = idx_q == 3'd0 ? op_q != OP_SUB : cout_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    op_q     <= req_op;
                    a_q      <= req_a;
                    b_q      <= req_b;
                    idx_q    <= 3'd0;
                    eq_acc_q <= 1'b1;
                    if (req_op > 3'd5) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        eq_q    <= 1'b0;
                    end else begin
                        state_q <= EXEC;
                        err_q   <= 1'b0;
                    end
                end
                EXEC: begin
                    res_q[8*idx_q +: 8] <= alu_f;
                    eq_acc_q <= eq_acc_q & alu_eq;
                    cout_q   <= alu_cout;
                    if (last) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        carry_q <= arith & ~alu_cout;
                        ovf_q   <= (op_q == OP_ADD || op_q == OP_SUB) & alu_ovf;
                        eq_q    <= eq_acc_q & alu_eq;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                DONE: if (rsp_ready) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_seq_ctrl.sv
// tb_ula_seq_ctrl: directed bench for ula_seq_ctrl with a behavioural 74181-style ALU attached
module tb_ula_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a, req_b, rsp_result;
    logic        rsp_carry, rsp_ovf, rsp_eq, rsp_err, busy;
    logic [7:0]  alu_a, alu_b, alu_f;
    logic [3:0]  alu_s;
    logic        alu_m, alu_cin, alu_cout, alu_eq, alu_ovf;
    int          checks = 0, errors = 0, lat;

    ula_seq_ctrl #(.NUM_BYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_eq(rsp_eq),
        .rsp_err(rsp_err), .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_m(alu_m), .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout),
        .alu_eq(alu_eq), .alu_ovf(alu_ovf)
    );

    always #5 clk = ~clk;

    // 74181 with active-high data: carries are active-low, A=B is high when F is all ones
    logic [7:0] bb;
    logic [8:0] sum;
    always_comb begin
        bb       = alu_s == 4'b1001 ? alu_b : ~alu_b;
        sum      = {1'b0, alu_a} + {1'b0, bb} + {8'b0, ~alu_cin};
        alu_f    = 8'h00;
        alu_cout = 1'b1;
        alu_ovf  = 1'b0;
        if (!alu_m) begin
            alu_f    = sum[7:0];
            alu_cout = ~sum[8];
            alu_ovf  = (alu_a[7] == bb[7]) && (sum[7] != alu_a[7]);
        end else begin
            alu_f = alu_s == 4'b1011 ? alu_a & alu_b : alu_s == 4'b1110 ? alu_a | alu_b :
                    alu_s == 4'b0110 ? alu_a ^ alu_b : 8'h00;
        end
        alu_eq = &alu_f;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = 16'hDEAD;
        req_b = 16'hBEEF;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic c, input logic o);
        issue(op, a, b);
        chk({tag, " valid"}, rsp_valid, 1'b1);
        chk({tag, " latency"}, lat, 3);
        chk({tag, " result"}, rsp_result, r);
        chk({tag, " carry"}, rsp_carry, c);
        chk({tag, " ovf"}, rsp_ovf, o);
        chk({tag, " err"}, rsp_err, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, " back to idle"}, req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_a = 16'h0;
        req_b = 16'h0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset req_ready", req_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset result", rsp_result, 16'h0);
        chk("reset eq", rsp_eq, 1'b0);
        chk("reset err", rsp_err, 1'b0);
        chk("idle alu_m/cin/s", {alu_m, alu_cin, alu_s}, 6'b110000);
        rst_n = 1'b1;

        run("add 12FF+1", 3'd0, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0);
        run("add FFFF+1", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run("add 7FFF+1", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        run("sub 8000-1", 3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        run("sub 0-1", 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
        run("cmp eq", 3'd5, 16'hA5A5, 16'hA5A5, 16'hFFFF, 1'b0, 1'b0);
        chk("cmp eq flag", rsp_eq, 1'b1);
        run("cmp gt", 3'd5, 16'hA5A5, 16'hA4A5, 16'h00FF, 1'b1, 1'b0);
        chk("cmp gt flag", rsp_eq, 1'b0);
        run("xor", 3'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0);
        run("and", 3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
        run("or", 3'd3, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0);

        rsp_ready = 1'b0;
        issue(3'd7, 16'h1234, 16'h5678);
        chk("illegal latency", lat, 1);
        chk("illegal err", rsp_err, 1'b1);
        chk("illegal result", rsp_result, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold valid", rsp_valid, 1'b1);
            chk("hold req_ready", req_ready, 1'b0);
            chk("hold result/flags", {rsp_result, rsp_err, rsp_carry, rsp_ovf, rsp_eq}, {16'h0, 4'b1000});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release valid", rsp_valid, 1'b0);
        chk("release req_ready", req_ready, 1'b1);
        chk("data kept err", rsp_err, 1'b1);

        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 16'h00FF;
        req_b = 16'h0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("exec busy", busy, 1'b1);
        chk("exec pass0 alu", {alu_a, alu_b, alu_s, alu_m, alu_cin}, {8'hFF, 8'h01, 4'b1001, 2'b01});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort rsp_valid", rsp_valid, 1'b0);
        chk("abort req_ready", req_ready, 1'b1);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("abort no response", rsp_valid, 1'b0);
        end
        run("add after reset", 3'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
